// File: rtl/axi_mem_ctrl_if.sv
// AXI4-Lite slave channels plus the single-port memory port, grouped so the
// controller and its neighbours share one bundle.
interface axi_mem_ctrl_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 10
);
    logic                      i_w_awvalid;
    logic                      o_w_awready;
    logic [ADDR_WIDTH-1:0]     i_w_awaddr;
    logic                      i_w_wvalid;
    logic                      o_w_wready;
    logic [DATA_WIDTH-1:0]     i_w_wdata;
    logic                      o_w_bvalid;
    logic                      i_w_bready;
    logic [1:0]                o_w_bresp;
    logic                      i_w_arvalid;
    logic                      o_w_arready;
    logic [ADDR_WIDTH-1:0]     i_w_araddr;
    logic                      o_w_rvalid;
    logic                      i_w_rready;
    logic [1:0]                o_w_rresp;
    logic [DATA_WIDTH-1:0]     o_w_rdata;
    logic                      o_w_mem_cs;
    logic                      o_w_mem_we;
    logic [MEM_ADDR_WIDTH-1:0] o_w_mem_addr;
    logic [DATA_WIDTH-1:0]     o_w_mem_wdata;
    logic [DATA_WIDTH-1:0]     i_w_mem_rdata;

    modport slave (
        input  i_w_awvalid, i_w_awaddr, i_w_wvalid, i_w_wdata, i_w_bready,
        input  i_w_arvalid, i_w_araddr, i_w_rready, i_w_mem_rdata,
        output o_w_awready, o_w_wready, o_w_bvalid, o_w_bresp,
        output o_w_arready, o_w_rvalid, o_w_rresp, o_w_rdata,
        output o_w_mem_cs, o_w_mem_we, o_w_mem_addr, o_w_mem_wdata
    );

    modport master (
        output i_w_awvalid, i_w_awaddr, i_w_wvalid, i_w_wdata, i_w_bready,
        output i_w_arvalid, i_w_araddr, i_w_rready, i_w_mem_rdata,
        input  o_w_awready, o_w_wready, o_w_bvalid, o_w_bresp,
        input  o_w_arready, o_w_rvalid, o_w_rresp, o_w_rdata,
        input  o_w_mem_cs, o_w_mem_we, o_w_mem_addr, o_w_mem_wdata
    );
endinterface

// File: rtl/axi_mem_ctrl.sv
// AXI4-Lite slave that serialises reads and writes onto one single-port
// synchronous memory, round-robin on collisions, SLVERR for out-of-range.
module axi_mem_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_DEPTH      = 1024,
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic           i_w_aclk,
    input  logic           i_w_areset,
    axi_mem_ctrl_if.slave  bus
);
    localparam int OFF = (DATA_WIDTH == 64) ? 3 : 2;

    typedef enum logic [2:0] {IDLE, WR_MEM, WR_RESP, RD_MEM, RD_CAP, RD_RESP} state_e;
    typedef enum logic {GR_READ, GR_WRITE} grant_e;

    state_e                    state_q, state_d;
    grant_e                    last_q, last_d;
    logic [MEM_ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                      inr_q, inr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic [1:0]                rresp_q, rresp_d;

    logic                  wr_elig, rd_elig, grant_wr, grant_rd;
    logic [ADDR_WIDTH-1:0] sel_addr, idx_full;
    logic                  in_range;

    // A write needs both AW and W; on a collision the type not granted last wins.
    assign wr_elig  = bus.i_w_awvalid && bus.i_w_wvalid;
    assign rd_elig  = bus.i_w_arvalid;
    assign grant_wr = (state_q == IDLE) && wr_elig && (!rd_elig || last_q == GR_READ);
    assign grant_rd = (state_q == IDLE) && rd_elig && !grant_wr;

    // Range check uses the full-width index so high addresses cannot alias.
    assign sel_addr = grant_wr ? bus.i_w_awaddr : bus.i_w_araddr;
    assign idx_full = sel_addr >> OFF;
    assign in_range = idx_full < ADDR_WIDTH'(MEM_DEPTH);

    always_ff @(posedge i_w_aclk) begin
        if (i_w_areset) begin
            state_q <= IDLE;
            last_q  <= GR_READ;
            idx_q   <= '0;
            inr_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            rresp_q <= 2'b00;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            inr_q   <= inr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        last_d          = last_q;
        idx_d           = idx_q;
        inr_d           = inr_q;
        wdata_d         = wdata_q;
        rdata_d         = rdata_q;
        rresp_d         = rresp_q;
        bus.o_w_awready = 1'b0;
        bus.o_w_wready  = 1'b0;
        bus.o_w_arready = 1'b0;
        bus.o_w_bvalid  = 1'b0;
        bus.o_w_bresp   = 2'b00;
        bus.o_w_rvalid  = 1'b0;
        bus.o_w_mem_cs  = 1'b0;
        bus.o_w_mem_we  = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_wr) begin
                    bus.o_w_awready = 1'b1;
                    bus.o_w_wready  = 1'b1;
                    last_d          = GR_WRITE;
                    idx_d           = idx_full[MEM_ADDR_WIDTH-1:0];
                    inr_d           = in_range;
                    wdata_d         = bus.i_w_wdata;
                    state_d         = WR_MEM;
                end else if (grant_rd) begin
                    bus.o_w_arready = 1'b1;
                    last_d          = GR_READ;
                    idx_d           = idx_full[MEM_ADDR_WIDTH-1:0];
                    inr_d           = in_range;
                    state_d         = RD_MEM;
                end
            end
            WR_MEM: begin
                bus.o_w_mem_cs = inr_q;
                bus.o_w_mem_we = inr_q;
                state_d        = WR_RESP;
            end
            WR_RESP: begin
                bus.o_w_bvalid = 1'b1;
                bus.o_w_bresp  = inr_q ? 2'b00 : 2'b10;
                if (bus.i_w_bready) state_d = IDLE;
            end
            RD_MEM: begin
                bus.o_w_mem_cs = inr_q;
                state_d        = RD_CAP;
            end
            RD_CAP: begin
                rdata_d = inr_q ? bus.i_w_mem_rdata : '0;
                rresp_d = inr_q ? 2'b00 : 2'b10;
                state_d = RD_RESP;
            end
            RD_RESP: begin
                bus.o_w_rvalid = 1'b1;
                if (bus.i_w_rready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset blocks new handshakes and any memory write pending this cycle.
        if (i_w_areset) begin
            bus.o_w_awready = 1'b0;
            bus.o_w_wready  = 1'b0;
            bus.o_w_arready = 1'b0;
            bus.o_w_mem_cs  = 1'b0;
            bus.o_w_mem_we  = 1'b0;
        end
    end

    assign bus.o_w_rdata     = rdata_q;
    assign bus.o_w_rresp     = rresp_q;
    assign bus.o_w_mem_addr  = idx_q;
    assign bus.o_w_mem_wdata = wdata_q;
endmodule

// File: tb/tb_axi_mem_ctrl.sv
// Directed bench for axi_mem_ctrl: vector table of single transactions plus
// hand sequences for collision, backpressure, partial write and reset.
module tb_axi_mem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    axi_mem_ctrl_if bus ();

    axi_mem_ctrl dut (
        .i_w_aclk   (clk),
        .i_w_areset (rst),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Single-port synchronous memory, one-cycle read latency.
    logic [31:0] mem [1024];
    always @(posedge clk) begin
        if (bus.o_w_mem_cs) begin
            if (bus.o_w_mem_we) mem[bus.o_w_mem_addr] <= bus.o_w_mem_wdata;
            else                bus.i_w_mem_rdata     <= mem[bus.o_w_mem_addr];
        end
    end

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
        bit          cs;
        logic [9:0]  midx;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_vec(input vec_t v);
        if (v.wr) begin
            tick(); bus.i_w_awvalid = 1; bus.i_w_wvalid = 1;
            bus.i_w_awaddr = v.addr; bus.i_w_wdata = v.data; bus.i_w_bready = 1;
            #1 chk("wr_awready", bus.o_w_awready, 1); chk("wr_wready", bus.o_w_wready, 1);
            tick(); bus.i_w_awvalid = 0; bus.i_w_wvalid = 0;
            #1 chk("wr_cs", bus.o_w_mem_cs, v.cs); chk("wr_we", bus.o_w_mem_we, v.cs);
            chk("wr_maddr", bus.o_w_mem_addr, v.midx); chk("wr_mwdata", bus.o_w_mem_wdata, v.data);
            tick(); #1 chk("wr_bvalid", bus.o_w_bvalid, 1); chk("wr_bresp", bus.o_w_bresp, v.resp);
            tick(); #1 chk("wr_bdone", bus.o_w_bvalid, 0);
        end else begin
            tick(); bus.i_w_arvalid = 1; bus.i_w_araddr = v.addr; bus.i_w_rready = 1;
            #1 chk("rd_arready", bus.o_w_arready, 1);
            tick(); bus.i_w_arvalid = 0;
            #1 chk("rd_cs", bus.o_w_mem_cs, v.cs); chk("rd_we", bus.o_w_mem_we, 0);
            chk("rd_maddr", bus.o_w_mem_addr, v.midx);
            tick(); #1 chk("rd_rvalid_t2", bus.o_w_rvalid, 0); chk("rd_cs_t2", bus.o_w_mem_cs, 0);
            tick(); #1 chk("rd_rvalid_t3", bus.o_w_rvalid, 1);
            chk("rd_rdata", bus.o_w_rdata, v.data); chk("rd_rresp", bus.o_w_rresp, v.resp);
            tick(); #1 chk("rd_rdone", bus.o_w_rvalid, 0);
        end
    endtask

    vec_t vecs [9];

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[1] = 32'hCAFEF00D;
        bus.i_w_awvalid = 0; bus.i_w_wvalid = 0; bus.i_w_arvalid = 0;
        bus.i_w_awaddr = 0; bus.i_w_wdata = 0; bus.i_w_araddr = 0;
        bus.i_w_bready = 0; bus.i_w_rready = 0; bus.i_w_mem_rdata = 0;

        vecs[0] = '{1, 32'h10,       32'hDEADBEEF, 2'b00, 1, 10'd4};
        vecs[1] = '{0, 32'h10,       32'hDEADBEEF, 2'b00, 1, 10'd4};
        vecs[2] = '{1, 32'h1000,     32'h12345678, 2'b10, 0, 10'd0};
        vecs[3] = '{0, 32'h1000,     32'h0,        2'b10, 0, 10'd0};
        vecs[4] = '{1, 32'hFFC,      32'hA5A5A5A5, 2'b00, 1, 10'd1023};
        vecs[5] = '{0, 32'hFFC,      32'hA5A5A5A5, 2'b00, 1, 10'd1023};
        vecs[6] = '{1, 32'h13,       32'h11112222, 2'b00, 1, 10'd4};
        vecs[7] = '{0, 32'h10,       32'h11112222, 2'b00, 1, 10'd4};
        vecs[8] = '{0, 32'h80000010, 32'h0,        2'b10, 0, 10'd4};

        // Reset: valids asserted must not produce readies.
        repeat (2) tick();
        bus.i_w_awvalid = 1; bus.i_w_wvalid = 1; bus.i_w_arvalid = 1;
        #1 chk("rst_awready", bus.o_w_awready, 0); chk("rst_wready", bus.o_w_wready, 0);
        chk("rst_arready", bus.o_w_arready, 0);
        tick(); bus.i_w_awvalid = 0; bus.i_w_wvalid = 0; bus.i_w_arvalid = 0;
        #1 chk("rst_bvalid", bus.o_w_bvalid, 0); chk("rst_rvalid", bus.o_w_rvalid, 0);
        chk("rst_cs", bus.o_w_mem_cs, 0); chk("rst_maddr", bus.o_w_mem_addr, 0);
        chk("rst_mwdata", bus.o_w_mem_wdata, 0); chk("rst_rdata", bus.o_w_rdata, 0);
        chk("rst_rresp", bus.o_w_rresp, 0); chk("rst_bresp", bus.o_w_bresp, 0);
        rst = 0;

        // Collision from reset: write wins, then pending read beats the next write.
        tick(); bus.i_w_awvalid = 1; bus.i_w_wvalid = 1; bus.i_w_awaddr = 32'h0; bus.i_w_wdata = 32'h1;
        bus.i_w_arvalid = 1; bus.i_w_araddr = 32'h4; bus.i_w_bready = 1; bus.i_w_rready = 1;
        #1 chk("col1_awready", bus.o_w_awready, 1); chk("col1_arready", bus.o_w_arready, 0);
        tick(); bus.i_w_awaddr = 32'h8; bus.i_w_wdata = 32'h2;
        #1 chk("col1_cs", bus.o_w_mem_cs, 1); chk("col1_we", bus.o_w_mem_we, 1);
        chk("col1_maddr", bus.o_w_mem_addr, 0); chk("col1_busy_ar", bus.o_w_arready, 0);
        tick(); #1 chk("col1_bvalid", bus.o_w_bvalid, 1); chk("col1_busy_aw", bus.o_w_awready, 0);
        tick(); #1 chk("col2_arready", bus.o_w_arready, 1); chk("col2_awready", bus.o_w_awready, 0);
        tick(); bus.i_w_arvalid = 0;
        #1 chk("col2_cs", bus.o_w_mem_cs, 1); chk("col2_maddr", bus.o_w_mem_addr, 1);
        tick(); tick(); #1 chk("col2_rvalid", bus.o_w_rvalid, 1); chk("col2_rdata", bus.o_w_rdata, 32'hCAFEF00D);
        tick(); #1 chk("col3_awready", bus.o_w_awready, 1);
        tick(); bus.i_w_awvalid = 0; bus.i_w_wvalid = 0;
        #1 chk("col3_maddr", bus.o_w_mem_addr, 2); chk("col3_mwdata", bus.o_w_mem_wdata, 2);
        tick(); tick();
        chk("col_mem0", mem[0], 32'h1); chk("col_mem2", mem[2], 32'h2);

        for (int i = 0; i < 9; i++) do_vec(vecs[i]);

        // Write backpressure with a read pending.
        tick(); bus.i_w_awvalid = 1; bus.i_w_wvalid = 1; bus.i_w_awaddr = 32'h20;
        bus.i_w_wdata = 32'h55; bus.i_w_bready = 0;
        #1 chk("bp_awready", bus.o_w_awready, 1);
        tick(); bus.i_w_awvalid = 0; bus.i_w_wvalid = 0; bus.i_w_arvalid = 1; bus.i_w_araddr = 32'h20;
        for (int i = 0; i < 5; i++) begin
            tick(); #1 chk("bp_bvalid", bus.o_w_bvalid, 1); chk("bp_bresp", bus.o_w_bresp, 0);
            chk("bp_arready", bus.o_w_arready, 0);
        end
        bus.i_w_bready = 1; bus.i_w_rready = 0;
        tick(); #1 chk("bp_bdone", bus.o_w_bvalid, 0); chk("bp_ar_go", bus.o_w_arready, 1);
        tick(); bus.i_w_arvalid = 0; bus.i_w_awvalid = 1; bus.i_w_wvalid = 1; bus.i_w_awaddr = 32'h24;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick(); #1 chk("bp_rvalid", bus.o_w_rvalid, 1); chk("bp_rdata", bus.o_w_rdata, 32'h55);
            chk("bp_rresp", bus.o_w_rresp, 0); chk("bp_awready", bus.o_w_awready, 0);
        end
        bus.i_w_rready = 1; bus.i_w_awvalid = 0; bus.i_w_wvalid = 0;
        tick(); #1 chk("bp_rdone", bus.o_w_rvalid, 0);

        // Partial write: AW alone must wait for W.
        bus.i_w_awvalid = 1; bus.i_w_awaddr = 32'h30; bus.i_w_wdata = 32'h77;
        for (int i = 0; i < 4; i++) begin
            #1 chk("pw_awready", bus.o_w_awready, 0); chk("pw_cs", bus.o_w_mem_cs, 0);
            tick();
        end
        bus.i_w_wvalid = 1;
        #1 chk("pw_go", bus.o_w_awready, 1);
        tick(); bus.i_w_awvalid = 0; bus.i_w_wvalid = 0;
        #1 chk("pw_cs1", bus.o_w_mem_cs, 1); chk("pw_maddr", bus.o_w_mem_addr, 12);
        tick(); #1 chk("pw_cs2", bus.o_w_mem_cs, 0); chk("pw_bvalid", bus.o_w_bvalid, 1);
        tick(); chk("pw_mem", mem[12], 32'h77);

        // Reset while in WR_MEM: write suppressed, no response.
        bus.i_w_awvalid = 1; bus.i_w_wvalid = 1; bus.i_w_awaddr = 32'h10; bus.i_w_wdata = 32'hBAD0BAD0;
        #1 chk("rw_awready", bus.o_w_awready, 1);
        tick(); bus.i_w_awvalid = 0; bus.i_w_wvalid = 0; rst = 1;
        #1 chk("rw_cs", bus.o_w_mem_cs, 0);
        tick(); rst = 0;
        #1 chk("rw_bvalid", bus.o_w_bvalid, 0); chk("rw_maddr", bus.o_w_mem_addr, 0);
        chk("rw_mwdata", bus.o_w_mem_wdata, 0);
        tick(); #1 chk("rw_bvalid2", bus.o_w_bvalid, 0);
        chk("rw_mem", mem[4], 32'h11112222);

        // Reset while in RD_RESP: response dropped.
        bus.i_w_arvalid = 1; bus.i_w_araddr = 32'h30; bus.i_w_rready = 0;
        tick(); bus.i_w_arvalid = 0;
        tick(); tick();
        #1 chk("rr_rvalid", bus.o_w_rvalid, 1); chk("rr_rdata", bus.o_w_rdata, 32'h77);
        rst = 1;
        tick(); rst = 0;
        #1 chk("rr_rvalid0", bus.o_w_rvalid, 0); chk("rr_rdata0", bus.o_w_rdata, 0);
        chk("rr_rresp0", bus.o_w_rresp, 0); chk("rr_arready", bus.o_w_arready, 0);
        tick(); #1 chk("rr_rvalid1", bus.o_w_rvalid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi_mem_ctrl.md
Name: axi_mem_ctrl

Overview:
- AXI4-Lite slave controller that sequences AW/W/B and AR/R transactions onto one single-port synchronous memory (cs/we/addr/wdata, 1-cycle read latency).
- Reads and writes share the port. Collisions are arbitrated round-robin.
- Out-of-range accesses are decoded here, are blocked from the memory, and return SLVERR.
- Sits between the AXI-Lite interconnect and the memory macro wrapper.

Parameters:
- ADDR_WIDTH, 32, AXI byte-address width.
- DATA_WIDTH, 32, data width; must be 32 or 64.
- MEM_DEPTH, 1024, number of memory words.
- MEM_ADDR_WIDTH, 10, memory word-index width; must equal clog2(MEM_DEPTH).

Ports:
- i_w_aclk  in  1  clock; all logic on rising edge.
- i_w_areset  in  1  synchronous, active-high reset.
- i_w_awvalid  in  1  write address valid.
- o_w_awready  out  1  write address ready.
- i_w_awaddr  in  ADDR_WIDTH  write byte address.
- i_w_wvalid  in  1  write data valid.
- o_w_wready  out  1  write data ready.
- i_w_wdata  in  DATA_WIDTH  write data.
- o_w_bvalid  out  1  write response valid.
- i_w_bready  in  1  write response ready.
- o_w_bresp  out  2  write response: 00 OKAY, 10 SLVERR.
- i_w_arvalid  in  1  read address valid.
- o_w_arready  out  1  read address ready.
- i_w_araddr  in  ADDR_WIDTH  read byte address.
- o_w_rvalid  out  1  read data valid.
- i_w_rready  in  1  read data ready.
- o_w_rresp  out  2  read response: 00 OKAY, 10 SLVERR.
- o_w_rdata  out  DATA_WIDTH  read data.
- o_w_mem_cs  out  1  memory chip select.
- o_w_mem_we  out  1  memory write enable.
- o_w_mem_addr  out  MEM_ADDR_WIDTH  memory word index.
- o_w_mem_wdata  out  DATA_WIDTH  memory write data.
- i_w_mem_rdata  in  DATA_WIDTH  memory read data; valid the cycle after cs=1, we=0.

Behaviour:
- FSM states: IDLE, WR_MEM, WR_RESP, RD_MEM, RD_CAP, RD_RESP. One transaction in flight at a time.
- Address decode:
  - Word index = addr >> log2(DATA_WIDTH/8); low byte-offset bits are ignored.
  - In range iff index < MEM_DEPTH, compared at full width before truncation to MEM_ADDR_WIDTH.
- IDLE, eligibility:
  - Write eligible iff i_w_awvalid && i_w_wvalid. AW without W, or W without AW, is never accepted alone.
  - Read eligible iff i_w_arvalid.
- IDLE, arbitration:
  - Both eligible: grant the type opposite to last_grant.
  - last_grant resets to READ, so the first collision grants the write.
  - last_grant updates on every grant.
- IDLE, handshake:
  - Granted channel readies are combinational from state/grant: awready=wready=1 for a write grant, arready=1 for a read grant.
  - All readies are 0 while i_w_areset=1 and in every state other than IDLE.
  - On handshake, register index, in-range flag, and wdata.
  - Next state: WR_MEM for a write, RD_MEM for a read.
- WR_MEM, one cycle:
  - In range: cs=1, we=1, addr/wdata from registers.
  - Out of range: cs=0.
  - Next: WR_RESP.
- WR_RESP:
  - bvalid=1; bresp=00 if in range, else 10.
  - Held stable until bready; on bvalid&&bready go to IDLE.
- RD_MEM, one cycle:
  - In range: cs=1, we=0, addr from register.
  - Out of range: cs=0.
  - Next: RD_CAP.
- RD_CAP, one cycle:
  - Latch rdata register = i_w_mem_rdata if in range, else 0.
  - Latch rresp = 00 if in range, else 10.
  - Next: RD_RESP.
- RD_RESP:
  - rvalid=1; rdata/rresp held stable until rready.
  - On rvalid&&rready go to IDLE.
- Latency (handshake cycle T):
  - Write: mem write at T+1; bvalid at T+2.
  - Read: mem access at T+1; rvalid at T+3.
  - With ready held high, back-to-back throughput is 1 write per 3 cycles and 1 read per 4 cycles.
- Memory outputs outside WR_MEM/RD_MEM: cs=0, we=0. addr/wdata hold their last registered values.
- Reset values (sync, next edge with i_w_areset=1):
  - State IDLE; last_grant READ.
  - All valid/ready = 0; bresp=00, rresp=00, rdata=0.
  - cs=0, we=0, mem addr=0, mem wdata=0.
- Reset mid-operation: any in-flight transaction is dropped with no response. A pending memory write in WR_MEM during the reset cycle is suppressed (cs=0).
- Inputs arriving while not in IDLE wait. Master-side valids are assumed held per AXI; no buffering here.

Test Plan:
- Write then read: AW/W addr 0x10, data 0xDEADBEEF, bready=1.
  - Required: cs=we=1, mem_addr=4 at T+1; bvalid, bresp=00 at T+2.
  - Then AR 0x10, rready=1: rvalid at T+3 with rdata=0xDEADBEEF, rresp=00.
- Collision: AW/W (0x0, 0x1) and AR (0x4) valid in the same cycle from reset.
  - Required: write granted first, arready=0 that cycle; read granted in the next IDLE.
  - Second collision: read granted first.
- Out of range: write to byte 0x1000 with MEM_DEPTH=1024.
  - Required: no cs pulse; bresp=10.
  - Read of 0x1000 → rresp=10, rdata=0, no cs.
- Backpressure: bready=0 for 5 cycles, then rready=0 for 5 cycles.
  - Required: bvalid/bresp and rvalid/rdata/rresp stable throughout; all readies 0; completion only on the ready cycle.
- Partial write: awvalid=1, wvalid=0 for 4 cycles, then wvalid=1.
  - Required: awready=0 until both are valid; single write executed.
- Reset in WR_MEM and in RD_RESP.
  - Required: next cycle all outputs at reset values.
  - Memory contents at the target word unchanged when reset is asserted in WR_MEM.
  - No b/r response issued.
